// File: rtl/mulalu.sv
// mulalu -- multi-cycle multiply/divide unit feeding the HI/LO registers.
// A multiply takes MUL_LAT busy cycles; a divide takes 32 restoring
// iterations on operand magnitudes. Results appear for one DONE cycle.
`ifndef FUNC_MUL
`define FUNC_MUL 5'b00001
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'b00010
`endif

module mulalu #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [4:0]  mulalu_func,
    input  logic        mulalu_sign,
    input  logic [31:0] source_a,
    input  logic [31:0] source_b,
    output logic        stall,
    output logic        hi_write,
    output logic [31:0] hi_write_data,
    output logic        lo_write,
    output logic [31:0] lo_write_data
);

    typedef enum logic [1:0] {IDLE, MBUSY, DBUSY, DONE} state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic        sign_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] bmag_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        start;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic s);
        return (s && v[31]) ? neg32(v) : v;
    endfunction

    // Start is recognised only in IDLE; a coincident flush cancels it.
    assign start = (state_q == IDLE) && (mulalu_func != 5'b00000) && !flush;

    // Hold EX from the start cycle through the last busy cycle; release in DONE.
    assign stall = !rst && !flush &&
                   (start || (state_q == MBUSY) || (state_q == DBUSY));

    // Strobes are live only in DONE and are cancelled by a flush in that cycle.
    assign hi_write      = !rst && !flush && (state_q == DONE);
    assign lo_write      = !rst && !flush && (state_q == DONE);
    assign hi_write_data = hi_q;
    assign lo_write_data = lo_q;

    // Sign- or zero-extend to 64 bits so one unsigned multiply serves both modes.
    assign a_ext = {(sign_q ? {32{a_q[31]}} : 32'b0), a_q};
    assign b_ext = {(sign_q ? {32{b_q[31]}} : 32'b0), b_q};
    assign prod  = a_ext * b_ext;

    // One restoring iteration: shift in the next dividend bit, try to subtract.
    always_comb begin
        rem_sh = {rem_q, quo_q[31]};
        trial  = rem_sh - {1'b0, bmag_q};
        if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
        end else begin
            rem_d = rem_sh[31:0];
            quo_d = {quo_q[30:0], 1'b0};
        end
    end

    // Restore signs on the final iteration; divide by zero has a fixed answer.
    always_comb begin
        q_fix = (sign_q && (a_q[31] ^ b_q[31])) ? neg32(quo_d) : quo_d;
        r_fix = (sign_q && a_q[31]) ? neg32(rem_d) : rem_d;
        if (b_q == 32'd0) begin
            div_lo = 32'hFFFF_FFFF;
            div_hi = a_q;
        end else begin
            div_lo = q_fix;
            div_hi = r_fix;
        end
    end

    // Control FSM with operand latches, iteration counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            sign_q  <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            bmag_q  <= 32'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q  <= mulalu_sign;
                        a_q     <= source_a;
                        b_q     <= source_b;
                        bmag_q  <= mag32(source_b, mulalu_sign);
                        quo_q   <= mag32(source_a, mulalu_sign);
                        rem_q   <= 32'd0;
                        cnt_q   <= 6'd0;
                        state_q <= (mulalu_func == `FUNC_DIV) ? DBUSY : MBUSY;
                    end
                end
                MBUSY: begin
                    if (cnt_q == MUL_LAST) begin
                        hi_q    <= prod[63:32];
                        lo_q    <= prod[31:0];
                        cnt_q   <= 6'd0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DBUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == DIV_LAST) begin
                        hi_q    <= div_hi;
                        lo_q    <= div_lo;
                        cnt_q   <= 6'd0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mulalu.md
MULALU -- requirements
Module: mulalu

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 2, giving the number of BUSY cycles for a multiply (legal 1..8).
REQ-002 The block SHALL have port clk  in  1  rising-edge clock.
REQ-003 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port flush  in  1  abort the current operation (pipeline flush or exception).
REQ-005 The block SHALL have port mulalu_func  in  5  operation select: `FUNC_MUL, `FUNC_DIV, or 5'b00000 for none.
REQ-006 The block SHALL have port mulalu_sign  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
REQ-007 The block SHALL have port source_a  in  32  multiplicand or dividend.
REQ-008 The block SHALL have port source_b  in  32  multiplier or divisor.
REQ-009 The block SHALL have port stall  out  1  high while the EX-stage instruction must be held.
REQ-010 The block SHALL have port hi_write  out  1  one-cycle HI write strobe.
REQ-011 The block SHALL have port hi_write_data  out  32  product[63:32] or remainder.
REQ-012 The block SHALL have port lo_write  out  1  one-cycle LO write strobe.
REQ-013 The block SHALL have port lo_write_data  out  32  product[31:0] or quotient.

Function
REQ-014 The FSM SHALL have the states IDLE, MBUSY, DBUSY and DONE.
REQ-015 In IDLE with mulalu_func != 0 and flush = 0 (start cycle T), the block SHALL latch the operands, op and sign, drive stall = 1 combinationally, and go to MBUSY or DBUSY.
REQ-016 In IDLE with mulalu_func = 0, the block SHALL hold stall = 0 and keep both write strobes low.
REQ-017 MBUSY SHALL last exactly MUL_LAT cycles; the multiply MAY be pipelined over those cycles, and DONE SHALL be in cycle T+1+MUL_LAT.
REQ-018 The multiply SHALL form a full 64-bit product, two's-complement when signed, zero-extended when unsigned.
REQ-019 DBUSY SHALL perform exactly 32 radix-2 restoring iterations on operand magnitudes, one per cycle, so DONE is in cycle T+33 regardless of operand values.
REQ-020 For a signed divide, quotient sign SHALL be sign(a) XOR sign(b) and remainder sign SHALL equal sign(a).
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO = 0x80000000 and HI = 0.
REQ-022 Divide by zero SHALL raise no exception, SHALL keep the same latency, and SHALL yield LO = 0xFFFFFFFF and HI = source_a for both signed and unsigned.
REQ-023 stall SHALL be 1 in the start cycle and in every MBUSY/DBUSY cycle, and SHALL be 0 in DONE.
REQ-024 In DONE, hi_write and lo_write SHALL both be 1 for exactly one cycle with the final results; the next state SHALL be IDLE unconditionally and inputs SHALL be ignored, so the held instruction leaving EX does not restart the op.
REQ-025 hi_write_data and lo_write_data SHALL hold their last values outside DONE; their value SHALL be don't-care whenever the strobes are low.
REQ-026 flush = 1 in any state SHALL force IDLE next cycle with no HI/LO write, and stall SHALL be 0 in the flush cycle.
REQ-027 flush = 1 coincident with a start condition SHALL prevent the start.
REQ-028 flush = 1 in DONE SHALL suppress both write strobes.
REQ-029 Input changes during MBUSY/DBUSY SHALL NOT affect the result, because only latched operands are used.

Reset
REQ-030 rst = 1 at a clock edge SHALL force IDLE with stall = 0, hi_write = 0, lo_write = 0, hi_write_data = 0, lo_write_data = 0, and all iteration counters and partial registers cleared.
REQ-031 rst SHALL take priority over flush and start, including mid-operation; an aborted op SHALL produce no write.

Verification
REQ-032 The bench SHALL cover: MULT, sign=1, a=0xFFFFFFFD, b=5 -> stall high for T..T+2, DONE at T+3 with HI=0xFFFFFFFF and LO=0xFFFFFFF1.
REQ-033 The bench SHALL cover: MULTU, a=0xFFFFFFFF, b=2 -> HI=0x00000001 and LO=0xFFFFFFFE at T+3.
REQ-034 The bench SHALL cover: DIV, sign=1, a=0xFFFFFFF9 (-7), b=2 -> stall high T..T+32, DONE at T+33 with LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-035 The bench SHALL cover: DIVU, a=7, b=0 -> LO=0xFFFFFFFF and HI=0x00000007 at T+33, with no other side effect.
REQ-036 The bench SHALL cover: DIV started at T with flush at T+10 -> no write strobes, stall=0 at T+10, and a new MULT at T+11 completes at T+14.
REQ-037 The bench SHALL cover: rst at T+5 during a DIV -> all outputs 0 from T+6, and no write strobe ever fires for the aborted op.
